bomber_info_data_packer: RTL



---
 rtl/bomber_info_data_packer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/bomber_info_data_packer.sv
// bomber_info_data_packer
//   Producer side of the 14-bit player-info word read by the info-text
//   renderer. Game logic hands in binary player state over valid/ready.
//   Each coordinate is clamped and then converted to a tens/units pair by a
//   5-cycle double-dabble. The packed word lands in a pending bank, which is
//   copied to the display bank on every vsync rising edge.
//
//   Packed word: [0] X tens, [4:1] X units, [5] Y tens, [9:6] Y units,
//                [11:10] lives, [13:12] bombs.
//
// Ports
//   i_pclk, i_rst_n          clock, async active-low reset
//   i_upd_valid/o_upd_ready  update handshake
//   i_upd_player             0 = player 1, 1 = player 2
//   i_pos_x, i_pos_y         binary tile positions (5b)
//   i_lives, i_bombs         2b counts
//   o_upd_done               1-cycle pulse on the pending-write cycle
//   i_vsync                  rising edge commits pending -> display
//   i_axi_addr, o_axi_data   zero-latency renderer read port
module bomber_info_data_packer #(
    parameter int POS_MAX   = 19,
    parameter int RST_LIVES = 3,
    parameter int RST_BOMBS = 1
) (
    input  logic        i_pclk,
    input  logic        i_rst_n,
    input  logic        i_upd_valid,
    output logic        o_upd_ready,
    input  logic        i_upd_player,
    input  logic [4:0]  i_pos_x,
    input  logic [4:0]  i_pos_y,
    input  logic [1:0]  i_lives,
    input  logic [1:0]  i_bombs,
    output logic        o_upd_done,
    input  logic        i_vsync,
    input  logic        i_axi_addr,
    output logic [13:0] o_axi_data
);

    localparam logic [13:0] RST_WORD = {2'(RST_BOMBS), 2'(RST_LIVES), 10'b0};
    localparam logic [4:0]  POS_LIM  = 5'(POS_MAX);

    typedef enum logic [1:0] {IDLE, CONV, WRITE} state_t;

    state_t            state;
    logic              player;
    logic [1:0]        lives;
    logic [1:0]        bombs;
    // Per axis shift register: [9] tens, [8:5] units, [4:0] binary operand.
    logic [1:0][9:0]   dd;
    logic [2:0]        cnt;
    logic [1:0][13:0]  pending;
    logic [1:0][13:0]  display;
    logic              vsync_q;
    logic              vsync_rise;
    logic [13:0]       word;

    function automatic logic [4:0] clamp(input logic [4:0] v);
        return (v > POS_LIM) ? POS_LIM : v;
    endfunction

    // One double-dabble iteration. The tens field is a single bit and can
    // never reach 5, so only the units nibble needs the add-3 correction.
    function automatic logic [9:0] dd_step(input logic [9:0] s);
        logic [9:0] t;
        t = s;
        if (t[8:5] >= 4'd5)
            t[8:5] = t[8:5] + 4'd3;
        return {t[8:0], 1'b0};
    endfunction

    assign vsync_rise = i_vsync & ~vsync_q;
    assign word       = {bombs, lives, dd[1][8:5], dd[1][9], dd[0][8:5], dd[0][9]};
    assign o_axi_data = display[i_axi_addr];

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            player      <= 1'b0;
            lives       <= 2'b0;
            bombs       <= 2'b0;
            dd          <= '0;
            cnt         <= 3'd0;
            pending     <= {RST_WORD, RST_WORD};
            display     <= {RST_WORD, RST_WORD};
            vsync_q     <= 1'b0;
            o_upd_ready <= 1'b1;
            o_upd_done  <= 1'b0;
        end else begin
            vsync_q    <= i_vsync;
            o_upd_done <= 1'b0;
            // Nonblocking copy: a commit on the WRITE cycle takes the
            // pre-write pending value, the new word waits for the next frame.
            if (vsync_rise)
                display <= pending;

            case (state)
                IDLE: begin
                    if (i_upd_valid) begin
                        player      <= i_upd_player;
                        lives       <= i_lives;
                        bombs       <= i_bombs;
                        dd[0]       <= {5'b0, clamp(i_pos_x)};
                        dd[1]       <= {5'b0, clamp(i_pos_y)};
                        cnt         <= 3'd0;
                        o_upd_ready <= 1'b0;
                        state       <= CONV;
                    end
                end
                CONV: begin
                    dd[0] <= dd_step(dd[0]);
                    dd[1] <= dd_step(dd[1]);
                    if (cnt == 3'd4) begin
                        cnt        <= 3'd0;
                        o_upd_done <= 1'b1;   // registered: high during WRITE
                        state      <= WRITE;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                WRITE: begin
                    pending[player] <= word;
                    o_upd_ready     <= 1'b1;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
